d25_txn_sched: RTL

//  Round-robin scheduler that shares one d25 req/ack/retry/busy/endtx target between N clients.
//  It grants one client at a time and drives the target's req.
//  It re-issues req after a retry, holds off while the target is busy, and ends each grant on endtx.

---
 rtl/d25_sched_pkg.sv | 17 +
 rtl/d25_rr_pick.sv | 31 +++
 rtl/d25_txn_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/d25_sched_pkg.sv
// d25_sched_pkg: shared types for the d25 transaction scheduler.
// Holds the FSM state enum and the owner-index width helper.
package d25_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    BACKOFF = 2'd3
  } sched_st_e;

  // Owner index width; never narrower than one bit.
  function automatic int sched_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/d25_rr_pick.sv
// d25_rr_pick: combinational round-robin picker.
// Scans requests starting at ptr_i; first hit wins.
module d25_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Rotating scan from the pointer, wrapping at N.
  always_comb begin : pick
    logic [IW-1:0] j;
    j     = '0;
    win_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/d25_txn_sched.sv
// d25_txn_sched: round-robin scheduler in front of one d25 target.
// Define D25_SCHED_RETRY_LIMIT_EN to abort a grant after MAX_RETRY.
module d25_txn_sched
  import d25_sched_pkg::*;
#(
  parameter  int N_CLI     = 4,
  parameter  int RETRY_GAP = 2,
  parameter  int MAX_RETRY = 3,
  localparam int ID_W      = sched_id_w(N_CLI)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CLI-1:0] cli_req,
  output logic [N_CLI-1:0] cli_gnt,
  output logic [N_CLI-1:0] cli_done,
  output logic [N_CLI-1:0] cli_err,
  output logic             req,
  input  logic             ack,
  input  logic             retry,
  input  logic             busy,
  input  logic             endtx,
  output logic [ID_W-1:0]  owner_id
);

  localparam int GW = $clog2(RETRY_GAP + 1);

  if (N_CLI < 2 || RETRY_GAP < 1 || MAX_RETRY < 0) begin : g_bad_cfg
    $error("d25_txn_sched: bad parameters");
  end

  sched_st_e        st_q,   st_d;
  logic [N_CLI-1:0] gnt_q,  gnt_d;
  logic [N_CLI-1:0] done_q, done_d;
  logic             req_q,  req_d;
  logic [ID_W-1:0]  own_q,  own_d;
  logic [ID_W-1:0]  rr_q,   rr_d;
  logic [GW-1:0]    gap_q,  gap_d;
  logic [ID_W-1:0]  nxt_rr;

  logic [N_CLI-1:0] win_w;
  logic [ID_W-1:0]  idx_w;
  logic             vld_w;

`ifdef D25_SCHED_RETRY_LIMIT_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [N_CLI-1:0] err_q,  err_d;
`endif

  d25_rr_pick #(
    .N  (N_CLI),
    .IW (ID_W)
  ) u_pick (
    .req_i (cli_req),
    .ptr_i (rr_q),
    .win_o (win_w),
    .idx_o (idx_w),
    .vld_o (vld_w)
  );

  assign nxt_rr = (own_q == ID_W'(N_CLI - 1)) ? '0 : own_q + 1'b1;

  // Next-state and output decode for the grant FSM.
  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    done_d = '0;
    req_d  = req_q;
    own_d  = own_q;
    rr_d   = rr_q;
    gap_d  = gap_q;
`ifdef D25_SCHED_RETRY_LIMIT_EN
    rcnt_d = rcnt_q;
    err_d  = '0;
`endif
    unique case (st_q)
      IDLE: begin
        if (vld_w && !busy) begin
          gnt_d = win_w;
          own_d = idx_w;
          req_d = 1'b1;
          st_d  = REQ;
        end
      end
      REQ: begin
        if (retry) begin
`ifdef D25_SCHED_RETRY_LIMIT_EN
          if (rcnt_q == RW'(MAX_RETRY)) begin
            err_d  = gnt_q;
            gnt_d  = '0;
            own_d  = '0;
            rr_d   = nxt_rr;
            rcnt_d = '0;
            req_d  = 1'b0;
            st_d   = IDLE;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
            req_d  = 1'b0;
            gap_d  = GW'(RETRY_GAP - 1);
            st_d   = BACKOFF;
          end
`else
          req_d = 1'b0;
          gap_d = GW'(RETRY_GAP - 1);
          st_d  = BACKOFF;
`endif
        end else if (ack) begin
          req_d = 1'b0;
          st_d  = XFER;
        end
      end
      BACKOFF: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (!busy) begin
          req_d = 1'b1;
          st_d  = REQ;
        end
      end
      XFER: begin
        if (endtx) begin
          done_d = gnt_q;
          gnt_d  = '0;
          own_d  = '0;
          rr_d   = nxt_rr;
          st_d   = IDLE;
`ifdef D25_SCHED_RETRY_LIMIT_EN
          rcnt_d = '0;
`endif
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      done_q <= '0;
      req_q  <= 1'b0;
      own_q  <= '0;
      rr_q   <= '0;
      gap_q  <= '0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
      req_q  <= req_d;
      own_q  <= own_d;
      rr_q   <= rr_d;
      gap_q  <= gap_d;
    end
  end

`ifdef D25_SCHED_RETRY_LIMIT_EN
  // Per-grant retry count and abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      err_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      err_q  <= err_d;
    end
  end
  assign cli_err = err_q;
`else
  assign cli_err = '0;
`endif

  assign cli_gnt  = gnt_q;
  assign cli_done = done_q;
  assign req      = req_q;
  assign owner_id = own_q;

endmodule
